fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, number of fetch-buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_addr  output  32  byte address to instruction memory, driven directly from the PC register.
REQ-006 imem_instr  input  32  instruction word; combinational read of imem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken from execute; flush and redirect.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 id_valid  output  1  buffer head holds a valid instruction for decode.
REQ-010 id_ready  input  1  decode accepts the head this cycle.
REQ-011 id_instr  output  32  head instruction; NOP 32'h00000013 when id_valid=0.
REQ-012 id_pc  output  32  PC of the head instruction; 0 when id_valid=0.
REQ-013 id_pc_plus4  output  32  id_pc+4, modulo 2^32.

Function
REQ-014 Pop occurs in a cycle with id_valid=1 and id_ready=1.
REQ-015 Push occurs in a cycle with redirect_valid=0 and buffer not full.
- A push is also allowed when the buffer is full and a pop occurs in the same cycle.
- A push writes {imem_addr, imem_instr} at the buffer tail.
- A push advances PC by 4.
REQ-016 With no push, PC holds.
- The memory read is speculative.
- A non-pushed read has no side effect.
REQ-017 PC increments modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-018 Push-to-decode latency:
- An instruction pushed in cycle N is visible at id_* in cycle N+1 at the earliest.
- id_* outputs are driven from registers only, with no combinational path from imem_instr.
REQ-019 Buffer order is strict FIFO.
- Occupancy ranges 0..BUF_DEPTH.
- Head and tail pointers wrap modulo BUF_DEPTH.
REQ-020 On a cycle with redirect_valid=1:
- All buffer entries are invalidated at the edge.
- PC <= {redirect_pc[31:2], 2'b00}.
- No push occurs.
- Any pop that cycle is discarded.
- id_valid=0 in cycle N+1.
- The first redirected instruction appears in cycle N+2.
REQ-021 redirect_valid is a single-cycle pulse.
- A held level re-applies every cycle.
- A held level therefore keeps the buffer empty and the PC pinned to the target.
REQ-022 When full and id_ready=0, no push occurs.
- PC holds.
- id_* outputs hold stable until a pop.
REQ-023 When empty, id_valid=0, id_instr=NOP, and id_pc=0.
REQ-024 Redirect has priority over both push and pop.

Reset
REQ-025 While rst=1:
- PC = RESET_PC.
- Buffer occupancy = 0.
- Pointers = 0.
- id_valid = 0.
- id_instr = NOP.
- id_pc = 0.
- imem_addr = RESET_PC.
REQ-026 Reset takes effect immediately, independent of clk.
- Reset asserted mid-operation discards all buffered entries and any pending redirect.
REQ-027 The first push occurs on the first rising edge with rst=0.

Structure
REQ-028 Shared package contains:
- RESET_PC default.
- NOP constant 32'h00000013.
- Fetch-entry typedef {pc[31:0], instr[31:0]}.
REQ-029 One sub-module, fetch_fifo:
- Parameterized by depth.
- Provides push/pop/flush/full/empty.
- Outputs the registered head.
- Holds the PC register and push/pop control logic outside it, in fetch_unit.

Verification
REQ-030 Memory programmed with 15 words, id_ready=1 constant, release reset -> id_pc sequence 0,4,8,...,0x38 on consecutive cycles; id_instr[2]=32'h00042583.
REQ-031 id_ready=0 from cycle 3 for 5 cycles -> fill behaviour:
- Buffer fills to BUF_DEPTH.
- imem_addr holds.
- id_pc holds stable.
- On release the sequence resumes with no skipped or duplicated PC.
REQ-032 Redirect pulse to 0x24 while 2 entries are buffered ->
- id_valid=0 in the next cycle.
- id_pc=0x24 in the cycle after that.
- The discarded PCs never appear at decode.
REQ-033 redirect_pc=0x27 -> PC loads 0x24 (low bits cleared).
REQ-034 RESET_PC=32'hFFFFFFF8, id_ready=1 -> id_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-035 Assert rst asynchronously mid-cycle with a full buffer -> outputs take reset values before the next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and fetch-entry type for the fetch unit
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;
  localparam logic [31:0] NOP_INSTR        = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - strict-FIFO fetch buffer with flush and registered head
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: empty_o masks stale entries.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, speculative imem read and buffered hand-off to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  logic [31:0]  pc_q, pc_d;
  logic         push, pop, full, empty;
  fetch_entry_t head, new_entry;

  // Redirect wins: it discards any pop and suppresses the push.
  always_comb begin
    pop       = id_valid && id_ready && !redirect_valid;
    push      = !redirect_valid && (!full || pop);
    new_entry = '{pc: pc_q, instr: imem_instr};
    pc_d      = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc & ~32'd3;
    else if (push)
      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign imem_addr   = pc_q;
  assign id_valid    = !empty;
  assign id_instr    = empty ? NOP_INSTR : head.instr;
  assign id_pc       = empty ? 32'd0 : head.pc;
  assign id_pc_plus4 = id_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  logic [31:0] imem_addr2, imem_instr2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'd0;
  logic        id_valid2;
  logic        id_ready2 = 1'b1;
  logic [31:0] id_instr2, id_pc2, id_pc_plus4_2;

  logic [31:0] rom [16];
  logic [31:0] hi_seq [4];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_instr  = (imem_addr < 32'd60) ? rom[imem_addr[5:2]] : NOP;
  assign imem_instr2 = ~imem_addr2;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8), .BUF_DEPTH(4)) dut_hi (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .id_valid(id_valid2), .id_ready(id_ready2), .id_instr(id_instr2),
    .id_pc(id_pc2), .id_pc_plus4(id_pc_plus4_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".instr"}, id_instr, rom[pc[5:2]]);
    chk({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, ".instr"}, id_instr, NOP);
    chk({tag, ".pc"}, id_pc, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'hA0000000 + i;
    rom[2]  = 32'h00042583;
    rom[15] = NOP;
    hi_seq[0] = 32'hFFFFFFF8; hi_seq[1] = 32'hFFFFFFFC;
    hi_seq[2] = 32'h00000000; hi_seq[3] = 32'h00000004;

    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #2;
    chk_empty("reset");
    chk("reset.imem_addr", imem_addr, 32'd0);
    chk("reset.hi_imem_addr", imem_addr2, 32'hFFFFFFF8);
    chk("reset.hi_valid", {31'd0, id_valid2}, 32'd0);

    // Streaming with decode always ready
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk_head($sformatf("stream%0d", k), 32'(4 * k));
      if (k < 4) begin
        chk($sformatf("wrap%0d.pc", k), id_pc2, hi_seq[k]);
        chk($sformatf("wrap%0d.instr", k), id_instr2, ~hi_seq[k]);
      end
    end
    chk("stream.instr2", id_instr == NOP ? 32'd0 : rom[2], 32'h00042583);

    // Stall: buffer fills, PC and head freeze, then resume in order
    rst = 1'b1; #1; rst = 1'b0;
    step(); chk_head("s0", 32'h00);
    step(); chk_head("s1", 32'h04);
    step(); chk_head("s2", 32'h08);
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_head($sformatf("stall%0d", k), 32'h08);
      chk($sformatf("stall%0d.imem_addr", k), imem_addr, 32'h10);
    end
    id_ready = 1'b1;
    step(); chk_head("resume0", 32'h0C);
    step(); chk_head("resume1", 32'h10);
    step(); chk_head("resume2", 32'h14);
    step(); chk_head("resume3", 32'h18);

    // Redirect to unaligned 0x27 with two entries buffered
    redirect_valid = 1'b1; redirect_pc = 32'h27;
    step();
    chk_empty("redir.n1");
    chk("redir.imem_addr", imem_addr, 32'h24);
    redirect_valid = 1'b0;
    step(); chk_head("redir.n2", 32'h24);
    step(); chk_head("redir.n3", 32'h28);

    // Held redirect keeps buffer empty and PC pinned
    redirect_valid = 1'b1; redirect_pc = 32'h08;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("hold%0d.valid", k), {31'd0, id_valid}, 32'd0);
      chk($sformatf("hold%0d.imem_addr", k), imem_addr, 32'h08);
    end
    redirect_valid = 1'b0;
    step(); chk_head("hold.after0", 32'h08);
    step(); chk_head("hold.after1", 32'h0C);

    // Asynchronous reset mid-cycle with a full buffer
    id_ready = 1'b0;
    step(); step();
    chk_head("full", 32'h0C);
    chk("full.imem_addr", imem_addr, 32'h14);
    #2; rst = 1'b1; #1;
    chk_empty("async_rst");
    chk("async_rst.imem_addr", imem_addr, 32'd0);
    chk("async_rst.pc4", id_pc_plus4, 32'd4);
    @(posedge clk); #1; rst = 1'b0; id_ready = 1'b1;
    step(); chk_head("restart0", 32'h00);
    step(); chk_head("restart1", 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
